moving_avg_ctrl: RTL and testbench

Sequencer for the single-channel moving-average filter. It paces samples into the filter at a programmable rate and flushes filter history on every mode change. It suppresses warm-up results and returns averaged samples over a ready/valid output with overrun/underrun accounting. Sits between the sample source (upstream valid/ready) and the filter's `enable`/`data_refresh`/`mode`/`din`/`dout` pins.

---
 rtl/moving_avg_ctrl_if.sv | 23 ++
 rtl/moving_avg_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_moving_avg_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/moving_avg_ctrl_if.sv
// Sample-in / result-out ready/valid bundle for moving_avg_ctrl.
// The controller takes the slave view; the source/sink environment takes the master view.
interface moving_avg_ctrl_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic [2:0]            m_mode;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_mode
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_mode
  );
endinterface

// File: rtl/moving_avg_ctrl.sv
// Paces samples into the moving-average filter, flushes it on mode change and hides warm-up results.
// Optional MAVG_CTRL_PULSE_GATE_EN: a captured result is offered only when flt_pulse is also high.
module moving_avg_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_en,
  input  logic [2:0]            cfg_mode,
  input  logic [DIV_WIDTH-1:0]  cfg_div,
  moving_avg_ctrl_if.slave      bus,
  output logic                  flt_enable,
  output logic                  flt_refresh,
  output logic [2:0]            flt_mode,
  output logic [DATA_WIDTH-1:0] flt_din,
  input  logic [DATA_WIDTH-1:0] flt_dout,
  input  logic                  flt_pulse,
  output logic [7:0]            underrun_cnt,
  output logic [7:0]            overrun_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_FLUSH_WAIT,
    S_RUN,
    S_ISSUE,
    S_CAPTURE
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [2:0]            r_act_mode;
  logic [DIV_WIDTH-1:0]  r_div;
  logic [3:0]            r_warm;
  logic                  r_hold_full;
  logic [DATA_WIDTH-1:0] r_hold_data;
  logic [DATA_WIDTH-1:0] r_din;
  logic                  r_m_valid;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic [2:0]            r_m_mode;
  logic [7:0]            r_underrun;
  logic [7:0]            r_overrun;

  logic                  w_load_cfg;
  logic                  w_div_dec;
  logic                  w_div_reload;
  logic                  w_underrun;
  logic                  w_capture;
  logic                  w_issue;
  logic                  w_flush;
  logic                  w_accept;
  logic                  w_pulse_ok;
  logic                  w_offer;
  logic                  w_m_load;
  logic                  w_overrun;
  logic [DATA_WIDTH-1:0] w_din;

  // Number of results to discard after a flush before the window is fully populated.
  function automatic logic [3:0] warmup_for(input logic [2:0] mode);
    case (mode)
      3'b001, 3'b010: return 4'd1;
      3'b011:         return 4'd3;
      3'b100:         return 4'd7;
      3'b101:         return 4'd15;
      default:        return 4'd0;
    endcase
  endfunction

  // NOTE: every signal assigned in always_comb gets a default up front, so no path can infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_load_cfg   = 1'b0;
    w_div_dec    = 1'b0;
    w_div_reload = 1'b0;
    w_underrun   = 1'b0;
    w_capture    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (cfg_en) w_state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        w_state_nxt = S_FLUSH_WAIT;
      end
      S_FLUSH_WAIT: begin
        w_load_cfg  = 1'b1;
        w_state_nxt = cfg_en ? S_RUN : S_IDLE;
      end
      S_RUN: begin
        if (!cfg_en) begin
          w_state_nxt = S_IDLE;
        end else if (cfg_mode != r_act_mode) begin
          w_state_nxt = S_FLUSH;
        end else if (r_div != '0) begin
          w_div_dec = 1'b1;
        end else if (r_hold_full) begin
          w_state_nxt = S_ISSUE;
        end else begin
          w_underrun   = 1'b1;
          w_div_reload = 1'b1;
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_capture    = 1'b1;
        w_div_reload = 1'b1;
        w_state_nxt  = cfg_en ? S_RUN : S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_issue  = (r_state == S_ISSUE);
  assign w_flush  = (r_state == S_FLUSH);
  assign w_accept = bus.s_valid && !r_hold_full && cfg_en;

`ifdef MAVG_CTRL_PULSE_GATE_EN
  assign w_pulse_ok = flt_pulse;
`else
  // The pulse is deliberately ignored in this build; OR-ing with one keeps it connected.
  assign w_pulse_ok = flt_pulse | 1'b1;
`endif

  assign w_offer   = w_capture && (r_warm == 4'd0) && w_pulse_ok;
  assign w_m_load  = w_offer && (!r_m_valid || bus.m_ready);
  assign w_overrun = w_offer && !w_m_load;

  // Filter drive: zeros during flush, held sample during issue, otherwise the last driven value.
  always_comb begin
    w_din = r_din;
    if (w_flush)      w_din = '0;
    else if (w_issue) w_din = r_hold_data;
  end

  assign flt_enable  = (r_state != S_IDLE);
  assign flt_refresh = w_flush || w_issue;
  assign flt_mode    = w_flush ? 3'b000 : r_act_mode;
  assign flt_din     = w_din;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_act_mode <= 3'b000;
      r_div      <= '0;
      r_warm     <= 4'd0;
      r_din      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_cfg) begin
        r_act_mode <= cfg_mode;
        r_warm     <= warmup_for(cfg_mode);
      end else if (w_capture && r_warm != 4'd0) begin
        r_warm <= r_warm - 4'd1;
      end
      if (w_load_cfg || w_div_reload) r_div <= cfg_div;
      else if (w_div_dec)             r_div <= r_div - 1'b1;
      if (flt_refresh) r_din <= w_din;
    end
  end

  // One-entry hold register; it survives IDLE and FLUSH so a queued sample is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_full <= 1'b0;
      r_hold_data <= '0;
    end else if (w_issue) begin
      r_hold_full <= 1'b0;
    end else if (w_accept) begin
      r_hold_full <= 1'b1;
      r_hold_data <= bus.s_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_mode  <= 3'b000;
    end else if (w_m_load) begin
      r_m_valid <= 1'b1;
      r_m_data  <= flt_dout;
      r_m_mode  <= r_act_mode;
    end else if (r_m_valid && bus.m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_underrun <= 8'd0;
      r_overrun  <= 8'd0;
    end else begin
      if (w_underrun && r_underrun != 8'hFF) r_underrun <= r_underrun + 8'd1;
      if (w_overrun && r_overrun != 8'hFF)   r_overrun  <= r_overrun + 8'd1;
    end
  end

  assign bus.s_ready  = !r_hold_full && cfg_en;
  assign bus.m_valid  = r_m_valid;
  assign bus.m_data   = r_m_data;
  assign bus.m_mode   = r_m_mode;
  assign underrun_cnt = r_underrun;
  assign overrun_cnt  = r_overrun;

endmodule

// File: tb/tb_moving_avg_ctrl.sv
// Directed bench for moving_avg_ctrl with a behavioural moving-average filter attached.
module tb_moving_avg_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cfg_en;
  logic [2:0]  cfg_mode;
  logic [15:0] cfg_div;
  logic        flt_enable;
  logic        flt_refresh;
  logic [2:0]  flt_mode;
  logic [15:0] flt_din;
  logic [15:0] flt_dout;
  logic        flt_pulse;
  logic [7:0]  underrun_cnt;
  logic [7:0]  overrun_cnt;

  moving_avg_ctrl_if #(.DATA_WIDTH(16)) bus ();

  moving_avg_ctrl #(.DATA_WIDTH(16), .DIV_WIDTH(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_en       (cfg_en),
    .cfg_mode     (cfg_mode),
    .cfg_div      (cfg_div),
    .bus          (bus.slave),
    .flt_enable   (flt_enable),
    .flt_refresh  (flt_refresh),
    .flt_mode     (flt_mode),
    .flt_din      (flt_din),
    .flt_dout     (flt_dout),
    .flt_pulse    (flt_pulse),
    .underrun_cnt (underrun_cnt),
    .overrun_cnt  (overrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural filter: mode 000 clears history and passes din; others average the last 2^k samples.
  logic [15:0] hist [16];

  function automatic logic [15:0] taps_avg(input logic [2:0] m, input logic [15:0] din);
    int n;
    int k;
    int sum;
    n = 1;
    k = 0;
    case (m)
      3'd1, 3'd2: begin n = 2;  k = 1; end
      3'd3:       begin n = 4;  k = 2; end
      3'd4:       begin n = 8;  k = 3; end
      3'd5:       begin n = 16; k = 4; end
      default:    begin n = 1;  k = 0; end
    endcase
    sum = int'($signed(din));
    for (int i = 0; i < n - 1; i++) sum += int'($signed(hist[i]));
    return 16'(sum >>> k);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) hist[i] <= 16'd0;
      flt_dout  <= 16'd0;
      flt_pulse <= 1'b0;
    end else begin
      flt_pulse <= flt_refresh;
      if (flt_refresh) begin
        if (flt_mode == 3'd0) begin
          for (int i = 0; i < 16; i++) hist[i] <= 16'd0;
          flt_dout <= flt_din;
        end else begin
          hist[0] <= flt_din;
          for (int i = 1; i < 16; i++) hist[i] <= hist[i-1];
          flt_dout <= taps_avg(flt_mode, flt_din);
        end
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Sample source: presents the queue head, pops it once the handshake completes.
  logic [15:0] tx_q [$];
  initial begin
    logic acc;
    bus.s_valid = 1'b0;
    bus.s_data  = 16'd0;
    forever begin
      @(negedge clk);
      acc = bus.s_valid && bus.s_ready;
      @(posedge clk);
      #1;
      if (acc && tx_q.size() > 0) void'(tx_q.pop_front());
      if (tx_q.size() > 0) begin
        bus.s_valid = 1'b1;
        bus.s_data  = tx_q[0];
      end else begin
        bus.s_valid = 1'b0;
      end
    end
  end

  // Result sink monitor.
  logic [15:0] rx_d [$];
  logic [2:0]  rx_m [$];
  int          rx_c [$];
  always @(negedge clk) begin
    if (rst_n && bus.m_valid && bus.m_ready) begin
      rx_d.push_back(bus.m_data);
      rx_m.push_back(bus.m_mode);
      rx_c.push_back(cyc);
    end
  end

  task automatic do_reset();
    rst_n       = 1'b0;
    cfg_en      = 1'b0;
    cfg_mode    = 3'd0;
    cfg_div     = 16'd0;
    bus.m_ready = 1'b1;
    tx_q.delete();
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    rx_d.delete();
    rx_m.delete();
    rx_c.delete();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_rx(input string tag, input int n, input int budget);
    int i;
    i = 0;
    while (rx_d.size() < n && i < budget) begin
      @(negedge clk);
      #1;
      i++;
    end
    check(tag, (rx_d.size() >= n), 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_ref;
    logic found;

    // Reset state
    rst_n       = 1'b0;
    cfg_en      = 1'b0;
    cfg_mode    = 3'd0;
    cfg_div     = 16'd0;
    bus.m_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_flt_enable", flt_enable, 0);
    check("rst_flt_refresh", flt_refresh, 0);
    check("rst_flt_mode", flt_mode, 0);
    check("rst_flt_din", flt_din, 0);
    check("rst_s_ready", bus.s_ready, 0);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_data", bus.m_data, 0);
    check("rst_m_mode", bus.m_mode, 0);
    check("rst_underrun", underrun_cnt, 0);
    check("rst_overrun", overrun_cnt, 0);

    // Mode 000, div 0: 5, -3, 7 pass straight through, one result every 3 cycles
    do_reset();
    tx_q.push_back(16'd5);
    tx_q.push_back(16'hFFFD);
    tx_q.push_back(16'd7);
    cfg_en = 1'b1;
    @(negedge clk);
    check("m0_idle_enable", flt_enable, 0);
    check("m0_idle_s_ready", bus.s_ready, 1);
    @(negedge clk);
    check("m0_flush_refresh", flt_refresh, 1);
    check("m0_flush_mode", flt_mode, 0);
    check("m0_flush_din", flt_din, 0);
    check("m0_flush_enable", flt_enable, 1);
    @(negedge clk);
    check("m0_fwait_refresh", flt_refresh, 0);
    wait_rx("m0_rx_count", 3, 100);
    check("m0_underrun", underrun_cnt, 0);
    if (rx_d.size() >= 3) begin
      check("m0_data0", rx_d[0], 16'd5);
      check("m0_data1", rx_d[1], 16'hFFFD);
      check("m0_data2", rx_d[2], 16'd7);
      check("m0_mode2", rx_m[2], 0);
      check("m0_period01", rx_c[1] - rx_c[0], 3);
      check("m0_period12", rx_c[2] - rx_c[1], 3);
    end

    // Mode 001: first result hidden by warm-up, then 6, 9
    do_reset();
    cfg_mode = 3'd1;
    tx_q.push_back(16'd4);
    tx_q.push_back(16'd8);
    tx_q.push_back(16'd10);
    cfg_en = 1'b1;
    wait_rx("m1_rx_count", 2, 100);
    if (rx_d.size() >= 2) begin
      check("m1_data0", rx_d[0], 16'd6);
      check("m1_data1", rx_d[1], 16'd9);
      check("m1_mode0", rx_m[0], 1);
    end

    // Mode 011 running, then switch to 000 between slots
    do_reset();
    cfg_mode = 3'd3;
    for (int i = 0; i < 4; i++) tx_q.push_back(16'd8);
    cfg_en = 1'b1;
    wait_rx("m3_rx_count", 1, 100);
    if (rx_d.size() >= 1) begin
      check("m3_data0", rx_d[0], 16'd8);
      check("m3_mode0", rx_m[0], 3);
    end
    repeat (5) @(posedge clk);
    #2;
    cfg_mode = 3'd0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (flt_refresh) begin
        found = 1'b1;
        check("sw_flush_mode", flt_mode, 0);
        check("sw_flush_din", flt_din, 0);
      end
    end
    check("sw_flush_seen", found, 1);
    @(posedge clk);
    #2;
    tx_q.push_back(16'd21);
    wait_rx("sw_rx_count", 2, 100);
    if (rx_d.size() >= 2) begin
      check("sw_data", rx_d[1], 16'd21);
      check("sw_mode", rx_m[1], 0);
    end

    // Backpressure: three results with m_ready low
    do_reset();
    bus.m_ready = 1'b0;
    tx_q.push_back(16'd11);
    tx_q.push_back(16'd22);
    tx_q.push_back(16'd33);
    cfg_en = 1'b1;
    repeat (30) @(posedge clk);
    #2;
    @(negedge clk);
    check("bp_m_valid", bus.m_valid, 1);
    check("bp_m_data", bus.m_data, 16'd11);
    check("bp_overrun", overrun_cnt, 2);
    @(posedge clk);
    #2;
    bus.m_ready = 1'b1;
    @(negedge clk);
    check("bp_hold_data", bus.m_data, 16'd11);
    @(negedge clk);
    check("bp_m_valid_drop", bus.m_valid, 0);
    check("bp_rx_count", rx_d.size(), 1);

    // Underrun: no samples, cfg_div=2, four slots
    do_reset();
    cfg_div = 16'd2;
    cfg_en  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("ur_flush_refresh", flt_refresh, 1);
    n_ref = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (flt_refresh) n_ref++;
    end
    check("ur_count4", underrun_cnt, 4);
    check("ur_no_refresh", n_ref, 0);
    @(posedge clk);
    #2;
    cfg_div = 16'd0;
    repeat (300) @(posedge clk);
    @(negedge clk);
    check("ur_saturate", underrun_cnt, 255);
    check("ur_overrun_zero", overrun_cnt, 0);

    // Asynchronous reset during ISSUE, then restart
    do_reset();
    tx_q.push_back(16'd9);
    cfg_en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (flt_refresh && flt_din == 16'd9) found = 1'b1;
    end
    check("rs_issue_seen", found, 1);
    rst_n  = 1'b0;
    cfg_en = 1'b0;
    @(posedge clk);
    #1;
    check("rs_flt_enable", flt_enable, 0);
    check("rs_flt_refresh", flt_refresh, 0);
    check("rs_flt_din", flt_din, 0);
    check("rs_s_ready", bus.s_ready, 0);
    check("rs_m_valid", bus.m_valid, 0);
    #1;
    rst_n  = 1'b1;
    cfg_en = 1'b1;
    @(negedge clk);
    check("rs_restart_idle", flt_enable, 0);
    @(negedge clk);
    check("rs_restart_flush", flt_refresh, 1);
    check("rs_restart_din", flt_din, 0);
    check("rs_restart_mode", flt_mode, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
